// File: rtl/gray_conv_arbiter.sv
// -----------------------------------------------------------------------------
// gray_conv_arbiter
//
// Shares one registered Gray-to-binary converter between NREQ Gray-coded
// sources. A round-robin arbiter picks one pending requester, captures its
// word, converts it and presents the binary result plus the requester index
// on a valid/ready output. There is one word in flight at a time.
//
// Parameters
//   WIDTH : Gray input / binary output width (>= 2)
//   NREQ  : number of requesters (power of two, 2..8)
//   IDW   : requester index width, equal to log2(NREQ)
//
// Ports
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   req_valid  : per-requester "word pending"
//   req_gray   : requester i word at [i*WIDTH +: WIDTH]
//   req_ready  : one-hot accept, only ever asserted in IDLE
//   out_valid  : converted result available
//   out_ready  : downstream accepts the result
//   out_bin    : converted binary value
//   out_id     : index of the requester that supplied the word
//   busy       : a word is in flight (CONVERT or HOLD)
//   conv_count : completed output handshakes, wraps 255 -> 0
//
// State table
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | arbitrating; req_ready offered to the round-robin winner
//   CONVERT  | captured word is converted into the output registers
//   HOLD     | result presented; waits for out_ready
// -----------------------------------------------------------------------------
module gray_conv_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_gray,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_bin,
  output logic [IDW-1:0]        out_id,
  output logic                  busy,
  output logic [7:0]            conv_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [IDW-1:0]   ptr;
  logic [WIDTH-1:0] gray_reg;
  logic [IDW-1:0]   id_reg;

  logic             grant_found;
  logic [IDW-1:0]   grant_id;
  logic [IDW-1:0]   cand;
  logic [WIDTH-1:0] grant_gray;
  logic             hs_in;
  logic             hs_out;

  // MSB passes through; every lower bit is the running XOR of the bits above.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Round-robin search starting at ptr. The index arithmetic wraps for free
  // because NREQ is a power of two and cand is exactly IDW bits wide.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr + k[IDW-1:0];
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  always_comb begin
    grant_gray = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == i[IDW-1:0]) begin
        grant_gray = req_gray[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and handshake decode. req_ready is combinational and masked by
  // rst so nothing is accepted in a reset cycle.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    hs_in     = 1'b0;
    hs_out    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_found && !rst) begin
          req_ready[grant_id] = 1'b1;
          hs_in               = 1'b1;
          state_nxt           = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_valid && out_ready) begin
          hs_out    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      gray_reg   <= '0;
      id_reg     <= '0;
      out_valid  <= 1'b0;
      out_bin    <= '0;
      out_id     <= '0;
      conv_count <= '0;
    end else begin
      if (hs_in) begin
        gray_reg <= grant_gray;
        id_reg   <= grant_id;
      end
      if (state == ST_CONVERT) begin
        out_bin   <= gray2bin(gray_reg);
        out_id    <= id_reg;
        out_valid <= 1'b1;
      end
      // Pointer moves past the requester just served, so it drops to the
      // lowest priority for the next grant.
      if (hs_out) begin
        out_valid  <= 1'b0;
        ptr        <= id_reg + 1'b1;
        conv_count <= conv_count + 8'd1;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_gray_conv_arbiter.sv
module tb_gray_conv_arbiter;

  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_gray;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_bin;
  logic [IDW-1:0]        out_id;
  logic                  busy;
  logic [7:0]            conv_count;

  gray_conv_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_gray   (req_gray),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bin    (out_bin),
    .out_id     (out_id),
    .busy       (busy),
    .conv_count (conv_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [IDW+WIDTH-1:0] sb[$];
  int                   hs_times[$];

  logic                 hold_prev = 1'b0;
  logic [WIDTH-1:0]     prev_bin;
  logic [IDW-1:0]       prev_id;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
  endfunction

  // Monitor: samples on the falling edge, pops the scoreboard whenever an
  // output handshake will occur on the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (hold_prev) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_bin",   32'(out_bin),   32'(prev_bin));
        chk("hold_id",    32'(out_id),    32'(prev_id));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          logic [IDW+WIDTH-1:0] e;
          e = sb.pop_front();
          chk("out_bin", 32'(out_bin), 32'(e[WIDTH-1:0]));
          chk("out_id",  32'(out_id),  32'(e[IDW+WIDTH-1:WIDTH]));
        end
        hs_times.push_back(cyc);
      end
    end
    hold_prev = out_valid && !out_ready && !rst;
    prev_bin  = out_bin;
    prev_id   = out_id;
  end

  // All driver tasks start and end at 2 time units after a rising edge.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 30; t++) begin
      if (!busy) break;
      @(posedge clk); #2;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_out_valid();
    for (int t = 0; t < 30; t++) begin
      if (out_valid) break;
      @(posedge clk); #2;
    end
    chk("valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic send(input int id, input logic [WIDTH-1:0] g,
                      input logic [WIDTH-1:0] expb, input logic chk_lat);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    req_valid = oh;
    req_gray  = '0;
    req_gray[id*WIDTH +: WIDTH] = g;
    #1;
    chk("req_ready_grant", 32'(req_ready), 32'(oh));
    @(posedge clk);
    sb.push_back({id[IDW-1:0], expb});
    #2;
    req_valid = '0;
    req_gray  = {NREQ*WIDTH{1'b1}} ^ {NREQ{g}};  // captured word must ignore this
    if (chk_lat) begin
      chk("lat_convert_valid", 32'(out_valid), 32'd0);
      chk("lat_convert_busy",  32'(busy),      32'd1);
      chk("lat_convert_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #2;
      chk("lat_out_valid", 32'(out_valid), 32'd1);
    end
  endtask

  logic [WIDTH-1:0] t2_gray[4] = '{4'b1000, 4'b1011, 4'b0101, 4'b0000};
  logic [WIDTH-1:0] t2_bin [4] = '{4'b1111, 4'b1101, 4'b0110, 4'b0000};
  int               fair_order[6] = '{0, 1, 2, 3, 0, 1};
  logic [WIDTH-1:0] fair_bin[4]   = '{4'b0001, 4'b0010, 4'b0011, 4'b0100};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 4'b0001;
    req_gray  = '0;
    out_ready = 1'b0;
    @(posedge clk); #2;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_out_bin",   32'(out_bin),   32'd0);
    chk("rst_out_id",    32'(out_id),    32'd0);
    chk("rst_count",     32'(conv_count), 32'd0);
    rst       = 1'b0;
    req_valid = '0;
    #1;
    chk("no_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #2;

    // Single request with latency check.
    out_ready = 1'b1;
    send(0, 4'b0110, 4'b0100, 1'b1);
    wait_idle();
    chk("count_after_first", 32'(conv_count), 32'd1);

    // Gray table through requester 2.
    for (int i = 0; i < 4; i++) begin
      send(2, t2_gray[i], t2_bin[i], 1'b0);
      wait_idle();
    end
    chk("count_after_table", 32'(conv_count), 32'd5);

    // Fairness with all requesters continuously valid.
    do_reset();
    begin
      int k;
      int s;
      k = 0;
      s = hs_times.size();
      req_gray  = {4'b0110, 4'b0010, 4'b0011, 4'b0001};
      req_valid = 4'b1111;
      out_ready = 1'b1;
      for (int t = 0; t < 60 && k < 6; t++) begin
        #1;
        if (req_ready != '0) begin
          logic [NREQ-1:0] oh;
          oh = '0;
          oh[fair_order[k]] = 1'b1;
          chk("fair_grant", 32'(req_ready), 32'(oh));
          sb.push_back({fair_order[k][IDW-1:0], fair_bin[fair_order[k]]});
          k++;
        end
        @(posedge clk); #2;
      end
      req_valid = '0;
      chk("fair_grant_count", 32'(k), 32'd6);
      wait_idle();
      for (int i = 1; i < 6; i++) begin
        if (s + i < hs_times.size())
          chk("fair_spacing", 32'(hs_times[s+i] - hs_times[s+i-1]), 32'd3);
        else
          chk("fair_out_count", 32'(hs_times.size() - s), 32'd6);
      end
    end

    // Backpressure: hold for 5 cycles with other requests pending.
    out_ready = 1'b0;
    send(1, 4'b1011, 4'b1101, 1'b0);
    wait_out_valid();
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_busy",      32'(busy),      32'd1);
      chk("bp_valid",     32'(out_valid), 32'd1);
      @(posedge clk); #2;
    end
    req_valid = '0;
    out_ready = 1'b1;
    wait_idle();
    chk("bp_count", 32'(conv_count), 32'd7);

    // Reset while holding a result.
    out_ready = 1'b0;
    send(1, 4'b1011, 4'b1101, 1'b0);
    wait_out_valid();
    chk("pre_rst_bin", 32'(out_bin), 32'b1101);
    do_reset();
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_bin",   32'(out_bin),   32'd0);
    chk("post_rst_busy",  32'(busy),      32'd0);
    chk("post_rst_count", 32'(conv_count), 32'd0);
    req_gray  = {4'b0000, 4'b0000, 4'b0000, 4'b0101};
    req_valid = 4'b1111;
    #1;
    chk("post_rst_ptr", 32'(req_ready), 32'b0001);
    @(posedge clk);
    sb.push_back({2'd0, 4'b0110});
    #2;
    req_valid = '0;
    out_ready = 1'b1;
    wait_idle();
    chk("post_rst_served", 32'(conv_count), 32'd1);

    // Counter wrap over 256 conversions.
    do_reset();
    out_ready = 1'b1;
    for (int n = 0; n < 256; n++) begin
      logic [WIDTH-1:0] g;
      g = n[WIDTH-1:0] ^ n[WIDTH+1:2];
      send(n % NREQ, g, g2b(g), 1'b0);
      wait_idle();
      if (n == 254) chk("wrap_255", 32'(conv_count), 32'd255);
      if (n == 255) chk("wrap_0",   32'(conv_count), 32'd0);
    end

    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
